// File: rtl/swap_regfile.sv
// swap_regfile: register file with a 3-phase swap sequencer (tmp<=A, A<=B, B<=tmp), a host write port and two read ports.
// SWAP_SAME_ADDR_SKIP_EN: equal-address swaps complete in one cycle without touching registers.
module swap_regfile #(
  parameter int DW = 8,
  parameter int AW = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          swap_valid,
  output logic          swap_ready,
  input  logic [AW-1:0] swap_addr_a,
  input  logic [AW-1:0] swap_addr_b,
  output logic          swap_done,
  output logic          busy,
  output logic [1:0]    phase,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  output logic          wr_drop,
  input  logic [AW-1:0] rd_addr_a,
  input  logic [AW-1:0] rd_addr_b,
  output logic [DW-1:0] rd_data_a,
  output logic [DW-1:0] rd_data_b
);
  localparam int NREGS = 2 ** AW;
  typedef enum logic [1:0] {IDLE = 2'd0, S1 = 2'd1, S2 = 2'd2, S3 = 2'd3} state_t;
  state_t state, state_n;
  logic [DW-1:0] regs [NREGS];
  logic [DW-1:0] tmp;
  logic [AW-1:0] addr_a_q, addr_b_q;
  logic accept, skip, go;
  assign swap_ready = (state == IDLE);
  assign busy = (state != IDLE);
  assign phase = state;
  assign accept = swap_valid && swap_ready;
`ifdef SWAP_SAME_ADDR_SKIP_EN
  assign skip = accept && (swap_addr_a == swap_addr_b);
`else
  assign skip = 1'b0;
`endif
  assign go = accept && !skip;
  assign rd_data_a = regs[rd_addr_a];
  assign rd_data_b = regs[rd_addr_b];
  // S1..S3 advance unconditionally; S3 + 1 wraps back to IDLE
  always_comb begin
    state_n = (state == IDLE) ? (go ? S1 : IDLE) : state_t'(state + 2'd1);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
      tmp <= '0;
      addr_a_q <= '0;
      addr_b_q <= '0;
      state <= IDLE;
      swap_done <= 1'b0;
      wr_drop <= 1'b0;
    end else begin
      state <= state_n;
      swap_done <= (state == S3) || skip;
      wr_drop <= wr_en && (state != IDLE);
      if (go) begin
        addr_a_q <= swap_addr_a;
        addr_b_q <= swap_addr_b;
      end
      if (wr_en && state == IDLE) regs[wr_addr] <= wr_data;
      if (state == S1) tmp <= regs[addr_a_q];
      if (state == S2) regs[addr_a_q] <= regs[addr_b_q];
      if (state == S3) regs[addr_b_q] <= tmp;
    end
  end
endmodule

// File: tb/tb_swap_regfile.sv
// tb_swap_regfile: directed-vector bench for swap_regfile.
module tb_swap_regfile;
  logic       clk = 1'b0;
  logic       reset, swap_valid, wr_en;
  logic [1:0] swap_addr_a, swap_addr_b, wr_addr, rd_addr_a, rd_addr_b, phase;
  logic [7:0] wr_data, rd_data_a, rd_data_b;
  logic       swap_ready, swap_done, busy, wr_drop;
  int n_cmp = 0;
  int n_err = 0;

  swap_regfile #(.DW(8), .AW(2)) dut (
    .clk(clk), .reset(reset), .swap_valid(swap_valid), .swap_ready(swap_ready),
    .swap_addr_a(swap_addr_a), .swap_addr_b(swap_addr_b), .swap_done(swap_done),
    .busy(busy), .phase(phase), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_drop(wr_drop), .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
    .rd_data_a(rd_data_a), .rd_data_b(rd_data_b)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [1:0] a, input logic [7:0] exp, input string tag);
    rd_addr_a = a;
    rd_addr_b = a;
    #1;
    check({tag, "_a"}, {24'd0, rd_data_a}, {24'd0, exp});
    check({tag, "_b"}, {24'd0, rd_data_b}, {24'd0, exp});
  endtask

  task automatic ctl(input logic [1:0] ph, input logic done, input string tag);
    check({tag, "_phase"}, {30'd0, phase}, {30'd0, ph});
    check({tag, "_busy"}, {31'd0, busy}, {31'd0, ph != 2'd0});
    check({tag, "_ready"}, {31'd0, swap_ready}, {31'd0, ph == 2'd0});
    check({tag, "_done"}, {31'd0, swap_done}, {31'd0, done});
  endtask

  task automatic write(input logic [1:0] a, input logic [7:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic issue(input logic [1:0] a, input logic [1:0] b);
    swap_valid = 1'b1; swap_addr_a = a; swap_addr_b = b;
  endtask

  initial begin
    reset = 1'b1; swap_valid = 1'b0; wr_en = 1'b0;
    swap_addr_a = '0; swap_addr_b = '0; wr_addr = '0; wr_data = '0;
    rd_addr_a = '0; rd_addr_b = '0;
    tick(); tick();
    reset = 1'b0;
    // 1: reset state, then held idle
    ctl(2'd0, 1'b0, "rst");
    check("rst_drop", {31'd0, wr_drop}, 32'd0);
    for (int i = 0; i < 4; i++) rd(i[1:0], 8'h00, "rst_rd");
    tick(); tick(); tick();
    ctl(2'd0, 1'b0, "idle3");
    for (int i = 0; i < 4; i++) rd(i[1:0], 8'h00, "idle3_rd");
    // 2: basic swap
    write(2'd1, 8'h11);
    write(2'd2, 8'h22);
    rd(2'd1, 8'h11, "w_r1");
    issue(2'd1, 2'd2);
    tick();
    swap_valid = 1'b0;
    ctl(2'd1, 1'b0, "sw_s1");
    tick();
    ctl(2'd2, 1'b0, "sw_s2");
    rd(2'd1, 8'h11, "sw_s2_r1");
    tick();
    ctl(2'd3, 1'b0, "sw_s3");
    rd(2'd1, 8'h22, "sw_s3_r1");
    rd(2'd2, 8'h22, "sw_s3_r2");
    tick();
    ctl(2'd0, 1'b1, "sw_done");
    rd(2'd1, 8'h22, "sw_r1");
    rd(2'd2, 8'h11, "sw_r2");
    tick();
    check("sw_done_pulse", {31'd0, swap_done}, 32'd0);
    // 3: same-cycle host write and swap accept
    write(2'd3, 8'h0F);
    issue(2'd1, 2'd3);
    wr_en = 1'b1; wr_addr = 2'd1; wr_data = 8'h5A;
    tick();
    swap_valid = 1'b0; wr_en = 1'b0;
    check("sc_drop", {31'd0, wr_drop}, 32'd0);
    tick(); tick(); tick();
    ctl(2'd0, 1'b1, "sc_done");
    rd(2'd1, 8'h0F, "sc_r1");
    rd(2'd3, 8'h5A, "sc_r3");
    tick();
    // 4: write during S2 is dropped; back-to-back accept on the done cycle
    issue(2'd0, 2'd1);
    tick();
    swap_valid = 1'b0;
    tick();
    ctl(2'd2, 1'b0, "dr_s2");
    wr_en = 1'b1; wr_addr = 2'd2; wr_data = 8'hEE;
    tick();
    wr_en = 1'b0;
    check("dr_drop", {31'd0, wr_drop}, 32'd1);
    tick();
    check("dr_drop_pulse", {31'd0, wr_drop}, 32'd0);
    ctl(2'd0, 1'b1, "dr_done");
    rd(2'd2, 8'h11, "dr_r2");
    rd(2'd0, 8'h0F, "dr_r0");
    rd(2'd1, 8'h00, "dr_r1");
    issue(2'd0, 2'd1);
    tick();
    swap_valid = 1'b0;
    ctl(2'd1, 1'b0, "b2b_s1");
    tick(); tick(); tick();
    ctl(2'd0, 1'b1, "b2b_done");
    rd(2'd0, 8'h00, "b2b_r0");
    rd(2'd1, 8'h0F, "b2b_r1");
    tick();
    // 5: reset mid-swap
    issue(2'd0, 2'd3);
    tick();
    swap_valid = 1'b0;
    tick();
    ctl(2'd2, 1'b0, "mr_s2");
    reset = 1'b1;
    tick();
    reset = 1'b0;
    ctl(2'd0, 1'b0, "mr_rst");
    for (int i = 0; i < 4; i++) rd(i[1:0], 8'h00, "mr_rd");
    tick();
    ctl(2'd0, 1'b0, "mr_after");
    tick();
    check("mr_nodone", {31'd0, swap_done}, 32'd0);
    // 6: equal-address swap
    write(2'd2, 8'h33);
    issue(2'd2, 2'd2);
    tick();
    swap_valid = 1'b0;
`ifdef SWAP_SAME_ADDR_SKIP_EN
    ctl(2'd0, 1'b1, "eq_skip");
    rd(2'd2, 8'h33, "eq_r2");
    tick();
    ctl(2'd0, 1'b0, "eq_after");
`else
    ctl(2'd1, 1'b0, "eq_s1");
    tick(); tick();
    check("eq_early", {31'd0, swap_done}, 32'd0);
    tick();
    ctl(2'd0, 1'b1, "eq_done");
    rd(2'd2, 8'h33, "eq_r2");
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
